// File: rtl/anpc3l_gate_monitor_pkg.sv
// Shared constants for the ANPC 3-level gate monitor: stable-pattern table, level/zero-type
// encodings, fault codes and FSM states. TDELAY_WIDTH normally comes from the fsm3lanpc package.
`ifndef TDELAY_WIDTH
`define TDELAY_WIDTH 8
`endif

package PKG_anpc3l_monitor;

  localparam int unsigned TDW = `TDELAY_WIDTH;
  typedef logic [TDW-1:0] dwell_t;

  // S_in bit order: bit0..bit5 = S1..S6
  localparam logic [5:0] PAT_P  = 6'b100011; // S1 S2 S6
  localparam logic [5:0] PAT_N  = 6'b011100; // S3 S4 S5
  localparam logic [5:0] PAT_O1 = 6'b010010; // S2 S5
  localparam logic [5:0] PAT_O2 = 6'b100100; // S3 S6
  localparam logic [5:0] PAT_O3 = 6'b110110; // S2 S3 S5 S6

  localparam logic [2:0] LEV_ZERO = 3'b000;
  localparam logic [2:0] LEV_POS  = 3'b001;
  localparam logic [2:0] LEV_NEG  = 3'b010;

  localparam logic [2:0] ZT_NONE = 3'd0;
  localparam logic [2:0] ZT_O1   = 3'd1;
  localparam logic [2:0] ZT_O2   = 3'd2;
  localparam logic [2:0] ZT_O3   = 3'd3;

  typedef enum logic [1:0] {
    CLS_TRANS     = 2'b00,
    CLS_STABLE    = 2'b01,
    CLS_FORBIDDEN = 2'b10
  } pat_class_t;

  typedef enum logic [1:0] {
    FC_NONE      = 2'b00,
    FC_FORBIDDEN = 2'b01,
    FC_DEADTIME  = 2'b10,
    FC_TIMEOUT   = 2'b11
  } fault_code_t;

  typedef enum logic [1:0] {
    ST_INIT   = 2'b00,
    ST_STABLE = 2'b01,
    ST_TRANS  = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

  // Shoot-through paths: outer+clamp on either side, or all four series switches
  function automatic logic pat_forbidden(input logic [5:0] s);
    return (s[0] & s[4]) | (s[3] & s[5]) | (&s[3:0]);
  endfunction

endpackage

// File: rtl/anpc3l_gate_monitor_decode.sv
// Combinational gate-pattern classifier: forbidden / stable (with level and zero type) / transitional.
module anpc3l_pattern_decode
  import PKG_anpc3l_monitor::*;
(
  input  logic [5:0] pattern,
  output pat_class_t pat_class,
  output logic [2:0] level,
  output logic [2:0] zero_type
);

  always_comb begin
    pat_class = CLS_TRANS;
    level     = LEV_ZERO;
    zero_type = ZT_NONE;
    if (pat_forbidden(pattern)) begin
      pat_class = CLS_FORBIDDEN;
    end else begin
      case (pattern)
        PAT_P:  begin pat_class = CLS_STABLE; level = LEV_POS; end
        PAT_N:  begin pat_class = CLS_STABLE; level = LEV_NEG; end
        PAT_O1: begin pat_class = CLS_STABLE; zero_type = ZT_O1; end
        PAT_O2: begin pat_class = CLS_STABLE; zero_type = ZT_O2; end
        PAT_O3: begin pat_class = CLS_STABLE; zero_type = ZT_O3; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/anpc3l_gate_monitor.sv
// ANPC 3-level gate-pattern monitor: level decode, dead-time and transition-timeout supervision,
// sticky fault. Commutation counter present only when ANPC_MON_COMM_CNT_EN is defined.
module anpc3l_gate_monitor
  import PKG_anpc3l_monitor::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [5:0]               S_in,
  input  logic [`TDELAY_WIDTH-1:0] t_dead_min,
  input  logic [`TDELAY_WIDTH-1:0] t_trans_max,
  input  logic                     fault_clr,
  output logic [2:0]               v_lev_out,
  output logic [2:0]               z_type_out,
  output logic                     valid,
  output logic                     fault,
  output logic [1:0]               fault_code,
  output logic [15:0]              comm_cnt
);

  logic [5:0]  s_reg;
  pat_class_t  cls;
  logic [2:0]  dec_lev;
  logic [2:0]  dec_zt;
  state_t      state;
  state_t      state_nx;
  fault_code_t code_q;
  fault_code_t code_nx;
  dwell_t      dwell;
  dwell_t      dwell_nx;
  logic [2:0]  lev_nx;
  logic [2:0]  zt_nx;
  logic        timeout;
  logic        dead_short;

  anpc3l_pattern_decode u_decode (
    .pattern   (s_reg),
    .pat_class (cls),
    .level     (dec_lev),
    .zero_type (dec_zt)
  );

  assign timeout    = (t_trans_max != '0) && (dwell >= t_trans_max);
  assign dead_short = (dwell < t_dead_min);

  always_comb begin
    state_nx = state;
    code_nx  = code_q;
    dwell_nx = dwell;
    lev_nx   = v_lev_out;
    zt_nx    = z_type_out;
    if (state == ST_FAULT) begin
      if (fault_clr && (cls != CLS_FORBIDDEN)) begin
        state_nx = ST_INIT;
        code_nx  = FC_NONE;
        dwell_nx = '0;
      end
    end else if (cls == CLS_FORBIDDEN) begin
      state_nx = ST_FAULT;
      code_nx  = FC_FORBIDDEN;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (cls == CLS_STABLE) begin
            state_nx = ST_STABLE;
            lev_nx   = dec_lev;
            zt_nx    = dec_zt;
          end
        end
        ST_STABLE: begin
          if (cls == CLS_TRANS) begin
            state_nx = ST_TRANS;
            dwell_nx = dwell_t'(1);
          end else if ((dec_lev != v_lev_out) || (dec_zt != z_type_out)) begin
            if (t_dead_min != '0) begin
              state_nx = ST_FAULT;
              code_nx  = FC_DEADTIME;
            end else begin
              lev_nx = dec_lev;
              zt_nx  = dec_zt;
            end
          end
        end
        ST_TRANS: begin
          // Dead-time outranks timeout when a stable code lands on the timeout cycle
          if ((cls == CLS_STABLE) && dead_short) begin
            state_nx = ST_FAULT;
            code_nx  = FC_DEADTIME;
          end else if (timeout) begin
            state_nx = ST_FAULT;
            code_nx  = FC_TIMEOUT;
          end else if (cls == CLS_STABLE) begin
            state_nx = ST_STABLE;
            lev_nx   = dec_lev;
            zt_nx    = dec_zt;
            dwell_nx = '0;
          end else if (dwell != '1) begin
            dwell_nx = dwell + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_reg      <= '0;
      state      <= ST_INIT;
      code_q     <= FC_NONE;
      dwell      <= '0;
      v_lev_out  <= LEV_ZERO;
      z_type_out <= ZT_NONE;
      valid      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      s_reg      <= S_in;
      state      <= state_nx;
      code_q     <= code_nx;
      dwell      <= dwell_nx;
      v_lev_out  <= lev_nx;
      z_type_out <= zt_nx;
      valid      <= (state_nx == ST_STABLE);
      fault      <= (state_nx == ST_FAULT);
    end
  end

  assign fault_code = code_q;

`ifdef ANPC_MON_COMM_CNT_EN
  logic [15:0] cnt_q;
  logic        commute;

  // v_lev_out doubles as the previous stable level; the first lock out of INIT only sets it
  assign commute = (state != ST_INIT) && (state_nx == ST_STABLE) && (lev_nx != v_lev_out);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (commute && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign comm_cnt = cnt_q;
`else
  assign comm_cnt = '0;
`endif

endmodule

// File: tb/tb_anpc3l_gate_monitor.sv
// Self-checking bench for anpc3l_gate_monitor: spec-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
`ifndef TDELAY_WIDTH
`define TDELAY_WIDTH 8
`endif

module tb_anpc3l_gate_monitor;

  localparam int TW  = `TDELAY_WIDTH;
  localparam int SAT = (1 << TW) - 1;
`ifdef ANPC_MON_COMM_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [5:0] P  = 6'b100011;
  localparam logic [5:0] N  = 6'b011100;
  localparam logic [5:0] O1 = 6'b010010;
  localparam logic [5:0] O2 = 6'b100100;
  localparam logic [5:0] O3 = 6'b110110;
  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] FB = 6'b010001;

  localparam int M_WAIT = 0;
  localparam int M_LOCK = 1;
  localparam int M_MOVE = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5:0]    S_in = 6'b100011;
  logic [TW-1:0] t_dead_min = '0;
  logic [TW-1:0] t_trans_max = '0;
  logic          fault_clr = 1'b0;
  logic [2:0]    v_lev_out;
  logic [2:0]    z_type_out;
  logic          valid;
  logic          fault;
  logic [1:0]    fault_code;
  logic [15:0]   comm_cnt;

  int errors = 0;
  int checks = 0;

  anpc3l_gate_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .S_in        (S_in),
    .t_dead_min  (t_dead_min),
    .t_trans_max (t_trans_max),
    .fault_clr   (fault_clr),
    .v_lev_out   (v_lev_out),
    .z_type_out  (z_type_out),
    .valid       (valid),
    .fault       (fault),
    .fault_code  (fault_code),
    .comm_cnt    (comm_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_mode;
  bit         m_faulted;
  int         m_code;
  int         m_run;
  int         m_cnt;
  logic [5:0] m_sreg;
  logic [2:0] m_lev;
  logic [2:0] m_zt;

  // 0 transitional, 1 stable, 2 forbidden
  function automatic int classify(input logic [5:0] s);
    if ((s[0] && s[4]) || (s[3] && s[5]) || (s[0] && s[1] && s[2] && s[3])) return 2;
    if (s == P || s == N || s == O1 || s == O2 || s == O3) return 1;
    return 0;
  endfunction

  // {level, zero type}
  function automatic logic [5:0] lookup(input logic [5:0] s);
    if (s == P)  return {3'b001, 3'd0};
    if (s == N)  return {3'b010, 3'd0};
    if (s == O1) return {3'b000, 3'd1};
    if (s == O2) return {3'b000, 3'd2};
    if (s == O3) return {3'b000, 3'd3};
    return 6'b0;
  endfunction

  task automatic m_lock(input logic [5:0] s, input bit counts);
    logic [5:0] d;
    d = lookup(s);
    if (CNT_EN && counts && (d[5:3] != m_lev) && (m_cnt < 65535)) m_cnt++;
    m_lev  = d[5:3];
    m_zt   = d[2:0];
    m_mode = M_LOCK;
  endtask

  task automatic m_step(input logic [5:0] x, input bit clr);
    int c;
    int rs;
    c  = classify(x);
    rs = (m_run > SAT) ? SAT : m_run;
    if (m_faulted) begin
      if (clr && c != 2) begin
        m_faulted = 1'b0;
        m_code    = 0;
        m_mode    = M_WAIT;
      end
    end else if (c == 2) begin
      m_faulted = 1'b1; m_code = 1;
    end else if (m_mode == M_WAIT) begin
      if (c == 1) m_lock(x, 1'b0);
    end else if (m_mode == M_LOCK) begin
      if (c == 0) begin
        m_mode = M_MOVE;
        m_run  = 1;
      end else if (lookup(x) != {m_lev, m_zt}) begin
        if (t_dead_min != 0) begin m_faulted = 1'b1; m_code = 2; end
        else m_lock(x, 1'b1);
      end
    end else begin
      if (c == 1 && rs < int'(t_dead_min)) begin
        m_faulted = 1'b1; m_code = 2;
      end else if (t_trans_max != 0 && rs >= int'(t_trans_max)) begin
        m_faulted = 1'b1; m_code = 3;
      end else if (c == 1) begin
        m_lock(x, 1'b1);
      end else begin
        m_run++;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_WAIT; m_faulted = 1'b0; m_code = 0; m_run = 0; m_cnt = 0;
      m_sreg = '0; m_lev = '0; m_zt = '0;
    end else begin
      m_step(m_sreg, fault_clr);
      m_sreg = S_in;
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("model_lev",   16'(v_lev_out),  16'(m_lev));
      chk("model_ztype", 16'(z_type_out), 16'(m_zt));
      chk("model_valid", 16'(valid),      16'(!m_faulted && m_mode == M_LOCK));
      chk("model_fault", 16'(fault),      16'(m_faulted));
      chk("model_code",  16'(fault_code), 16'(m_code));
      chk("model_cnt",   comm_cnt,        16'(m_cnt));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [5:0] pat, input int n);
    S_in = pat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
  endtask

  task automatic async_reset_check();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_lev",   16'(v_lev_out),  16'd0);
    chk("async_rst_valid", 16'(valid),      16'd0);
    chk("async_rst_fault", 16'(fault),      16'd0);
    chk("async_rst_code",  16'(fault_code), 16'd0);
    chk("async_rst_cnt",   comm_cnt,        16'd0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  logic [5:0] pats [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    pats = '{O1, N, O2, O3, P};
    t_dead_min  = TW'(3);
    t_trans_max = '0;

    // Reset state, then P held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lev",   16'(v_lev_out),  16'd0);
    chk("rst_ztype", 16'(z_type_out), 16'd0);
    chk("rst_valid", 16'(valid),      16'd0);
    chk("rst_fault", 16'(fault),      16'd0);
    chk("rst_code",  16'(fault_code), 16'd0);
    chk("rst_cnt",   comm_cnt,        16'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("first_sample_valid", 16'(valid), 16'd0);
    @(posedge clk); #1;
    chk("p_valid", 16'(valid),      16'd1);
    chk("p_lev",   16'(v_lev_out),  16'b001);
    chk("p_ztype", 16'(z_type_out), 16'd0);

    // Legal transition P -> 4x zero -> O1
    step(Z, 4);
    chk("trans_valid", 16'(valid),     16'd0);
    chk("trans_lev",   16'(v_lev_out), 16'b001);
    step(O1, 2);
    chk("o1_lev",   16'(v_lev_out),  16'd0);
    chk("o1_ztype", 16'(z_type_out), 16'd1);
    chk("o1_valid", 16'(valid),      16'd1);
    chk("o1_fault", 16'(fault),      16'd0);
    chk("o1_cnt",   comm_cnt,        CNT_EN ? 16'd1 : 16'd0);

    // Dwell exactly t_dead_min is accepted
    step(Z, 3);
    step(P, 2);
    chk("dead_eq_valid", 16'(valid), 16'd1);
    chk("dead_eq_fault", 16'(fault), 16'd0);

    // Dwell too short -> dead-time fault
    step(Z, 2);
    step(N, 2);
    chk("dead_short_fault", 16'(fault),      16'd1);
    chk("dead_short_code",  16'(fault_code), 16'b10);
    chk("dead_short_valid", 16'(valid),      16'd0);
    pulse_clr();
    chk("clr_fault", 16'(fault),      16'd0);
    chk("clr_code",  16'(fault_code), 16'd0);
    chk("clr_valid", 16'(valid),      16'd0);
    @(posedge clk); #1;
    chk("relock_valid", 16'(valid),     16'd1);
    chk("relock_lev",   16'(v_lev_out), 16'b010);

    // Transition timeout at dwell 10
    t_trans_max = TW'(10);
    step(Z, 11);
    chk("pre_timeout_fault", 16'(fault), 16'd0);
    step(Z, 1);
    chk("timeout_fault", 16'(fault),      16'd1);
    chk("timeout_code",  16'(fault_code), 16'b11);
    pulse_clr();
    chk("timeout_clr_fault", 16'(fault), 16'd0);
    step(Z, 3);
    chk("init_hold_valid", 16'(valid), 16'd0);

    // Dwell just under timeout is accepted
    t_trans_max = TW'(5);
    step(P, 2);
    chk("init_lock_valid", 16'(valid), 16'd1);
    step(Z, 4);
    step(O2, 2);
    chk("under_tmax_valid", 16'(valid),      16'd1);
    chk("under_tmax_ztype", 16'(z_type_out), 16'd2);

    // Forbidden on the timeout cycle wins; clr ignored while forbidden persists
    t_trans_max = TW'(10);
    step(Z, 10);
    step(FB, 2);
    chk("forb_fault", 16'(fault),      16'd1);
    chk("forb_code",  16'(fault_code), 16'b01);
    pulse_clr();
    chk("forb_clr_fault", 16'(fault),      16'd1);
    chk("forb_clr_code",  16'(fault_code), 16'b01);
    step(O3, 2);
    pulse_clr();
    chk("o3_clr_fault", 16'(fault), 16'd0);
    @(posedge clk); #1;
    chk("o3_ztype", 16'(z_type_out), 16'd3);

    // Direct stable-to-stable change with dead time required
    t_dead_min  = TW'(255);
    t_trans_max = '0;
    step(N, 2);
    chk("direct_code", 16'(fault_code), 16'b10);
    async_reset_check();
    step(N, 2);
    chk("post_rst_valid", 16'(valid),     16'd1);
    chk("post_rst_lev",   16'(v_lev_out), 16'b010);

    // Dwell counter saturates rather than wrapping
    step(Z, 300);
    step(P, 2);
    chk("sat_valid", 16'(valid), 16'd1);
    chk("sat_fault", 16'(fault), 16'd0);

    // Dead-time check disabled: direct change is legal
    t_dead_min = '0;
    step(N, 2);
    chk("nodead_valid", 16'(valid),     16'd1);
    chk("nodead_lev",   16'(v_lev_out), 16'b010);

    // Reset mid-transition, then commutation cycling
    t_dead_min  = TW'(2);
    t_trans_max = TW'(20);
    step(Z, 3);
    async_reset_check();
    step(P, 3);
    chk("cyc_start_cnt", comm_cnt, 16'd0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) begin
        step(Z, 2);
        step(pats[i], 3);
      end
    end
    chk("cyc_cnt",   comm_cnt,     CNT_EN ? 16'd12 : 16'd0);
    chk("cyc_valid", 16'(valid),   16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/anpc3l_gate_monitor.md
ANPC3L_GATE_MONITOR -- requirements
Module: anpc3l_gate_monitor

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port S_in  input  6  gate pattern, bit0..bit5 = S1..S6 (S1/S4 outer, S2/S3 inner, S5/S6 clamp).
REQ-004 SHALL have port t_dead_min  input  `TDELAY_WIDTH  minimum transitional dwell in cycles; 0 disables the check.
REQ-005 SHALL have port t_trans_max  input  `TDELAY_WIDTH  maximum transitional dwell in cycles; 0 disables the timeout.
REQ-006 SHALL have port fault_clr  input  1  single-cycle fault clear request.
REQ-007 SHALL have port v_lev_out  output  3  decoded level: 000 zero, 001 positive, 010 negative.
REQ-008 SHALL have port z_type_out  output  3  decoded zero type 1..3; 0 when level is not zero.
REQ-009 SHALL have port valid  output  1  high only in STABLE.
REQ-010 SHALL have port fault  output  1  sticky fault flag.
REQ-011 SHALL have port fault_code  output  2  01 forbidden pattern, 10 dead-time violation, 11 transition timeout.
REQ-012 SHALL have port comm_cnt  output  16  count of level commutations.

Function
REQ-013 SHALL register S_in once; decode and state update use the registered copy; outputs are registered, so any S_in change is reflected on outputs exactly 2 cycles later.
REQ-014 SHALL classify each registered pattern as STABLE-code (P, N, O1, O2, O3, per package table), FORBIDDEN ((S1&S5)|(S4&S6)|(S1&S2&S3&S4)), or TRANSITIONAL (all other patterns, including 000000).
REQ-015 SHALL implement states INIT, STABLE, TRANS, FAULT.
REQ-016 INIT: stays until a STABLE-code appears, then goes to STABLE; no timeout or dead-time checks in INIT.
REQ-017 STABLE: outputs hold decoded level/type; pattern change to TRANSITIONAL -> TRANS with dwell counter cleared to 1.
REQ-018 STABLE: direct change to a different STABLE-code with t_dead_min>0 -> FAULT, code 10.
REQ-019 TRANS: dwell counter increments each cycle, saturating at all-ones; outputs hold last stable decode, valid=0.
REQ-020 TRANS -> STABLE on a STABLE-code if dwell >= t_dead_min, else FAULT code 10.
REQ-021 TRANS -> FAULT code 11 when t_trans_max>0 and dwell reaches t_trans_max.
REQ-022 Any state: FORBIDDEN pattern -> FAULT code 01 next cycle; priority 01 > 10 > 11 on simultaneous events.
REQ-023 FAULT: fault=1, valid=0, fault_code keeps the first cause; later causes ignored.
REQ-024 FAULT -> INIT on fault_clr=1 only if the current registered pattern is not FORBIDDEN; otherwise clr is ignored.
REQ-025 fault_clr outside FAULT SHALL have no effect.
REQ-026 comm_cnt SHALL increment on each STABLE entry whose level differs from the previous stable level; saturates at 16'hFFFF; not cleared by fault_clr.

Reset
REQ-027 On reset low: state INIT, S_in register 000000, v_lev_out 000, z_type_out 000, valid 0, fault 0, fault_code 00, dwell 0, comm_cnt 0, previous level = zero.
REQ-028 Reset asserted mid-transition or in FAULT SHALL clear everything immediately, independent of clk.

Configuration
REQ-029 Macro ANPC_MON_COMM_CNT_EN: defined -> commutation counter per REQ-026; undefined -> counter logic omitted, comm_cnt tied to 0, port retained.

Structure
REQ-030 Package PKG_anpc3l_monitor SHALL hold the stable-pattern constants, level and zero-type encodings, fault_code enum and state enum; `TDELAY_WIDTH comes from the existing fsm3lanpc package.
REQ-031 Pattern classification SHALL be a combinational sub-module anpc3l_pattern_decode (pattern in; class, level, zero type out).

Verification
REQ-032 Reset release, S_in=P held -> valid=1, v_lev_out=001 two cycles after first sample.
REQ-033 t_dead_min=3, P -> 000000 for 4 cycles -> O1 -> STABLE, v_lev_out=000, z_type_out=1, comm_cnt=1, fault=0.
REQ-034 t_dead_min=3, P -> 000000 for 2 cycles -> N -> fault=1, fault_code=10.
REQ-035 t_trans_max=10, P -> 000000 held -> fault_code=11 exactly after dwell 10; fault_clr with 000000 -> INIT, fault=0.
REQ-036 S_in=010001 (S1&S5) during TRANS with dwell=t_trans_max same cycle -> fault_code=01; fault_clr while pattern persists -> fault stays 1.
REQ-037 Cycle P/O1/N/O2 repeatedly with legal dead time -> comm_cnt counts level changes; undefined macro -> comm_cnt stays 0.
